// File: rtl/dec_exe_stage_reg_if.sv
// DEC->EXE stage bundle: instruction state and forwarded operands from DEC,
// registered EXE state and hazard statistics back to the pipeline.
interface dec_exe_stage_reg_if #(
  parameter int CNT_W = 16
);
  logic             dec_valid;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_insn;
  logic [4:0]       dec_rd;
  logic             dec_rd_wenb;
  logic             dec_load;
  logic             dec_csr;
  logic [31:0]      dec_rs1_data;
  logic [31:0]      dec_rs2_data;
  logic             dec_stall;
  logic             dec_load_use;
  logic             dec_csr_use;
  logic             exe_busy;
  logic             flush;
  logic             dec_hold;
  logic             exe_valid;
  logic [31:0]      exe_pc;
  logic [31:0]      exe_insn;
  logic [31:0]      exe_rs1_data;
  logic [31:0]      exe_rs2_data;
  logic [4:0]       exe_rd;
  logic             exe_rd_wenb;
  logic             exe_load;
  logic             exe_csr;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] csr_use_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  // Pipeline side: drives DEC state and control, observes EXE state.
  modport master (
    output dec_valid, dec_pc, dec_insn, dec_rd, dec_rd_wenb, dec_load, dec_csr,
           dec_rs1_data, dec_rs2_data, dec_stall, dec_load_use, dec_csr_use,
           exe_busy, flush,
    input  dec_hold, exe_valid, exe_pc, exe_insn, exe_rs1_data, exe_rs2_data,
           exe_rd, exe_rd_wenb, exe_load, exe_csr,
           load_use_cnt, csr_use_cnt, bubble_cnt
  );

  // Stage register side.
  modport slave (
    input  dec_valid, dec_pc, dec_insn, dec_rd, dec_rd_wenb, dec_load, dec_csr,
           dec_rs1_data, dec_rs2_data, dec_stall, dec_load_use, dec_csr_use,
           exe_busy, flush,
    output dec_hold, exe_valid, exe_pc, exe_insn, exe_rs1_data, exe_rs2_data,
           exe_rd, exe_rd_wenb, exe_load, exe_csr,
           load_use_cnt, csr_use_cnt, bubble_cnt
  );
endinterface

// File: rtl/dec_exe_stage_reg.sv
// DEC->EXE pipeline register: captures forwarded operands, inserts bubbles on
// DEC stalls, holds while EXE is busy, squashes on flush, and keeps saturating
// load-use / CSR-use / bubble counters.
module dec_exe_stage_reg #(
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  dec_exe_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } action_e;

  action_e          action;
  logic             valid_q;
  logic [31:0]      pc_q;
  logic [31:0]      insn_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic [4:0]       rd_q;
  logic             rd_wenb_q;
  logic             load_q;
  logic             csr_q;
  logic [CNT_W-1:0] load_use_q;
  logic [CNT_W-1:0] csr_use_q;
  logic [CNT_W-1:0] bubble_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Pick the single action for this edge: flush > hold > bubble > advance.
  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    action = ACT_ADVANCE;
    if (bus.flush)                           action = ACT_FLUSH;
    else if (bus.exe_busy)                   action = ACT_HOLD;
    else if (bus.dec_stall && bus.dec_valid) action = ACT_BUBBLE;
  end

  // DEC must keep its instruction whenever it cannot move into EXE this cycle.
  assign bus.dec_hold = ~reset & bus.dec_valid & ~bus.flush & (bus.exe_busy | bus.dec_stall);

  // Control fields: cleared by flush and bubble, frozen on hold, captured on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      valid_q   <= 1'b0;
      rd_q      <= '0;
      rd_wenb_q <= 1'b0;
      load_q    <= 1'b0;
      csr_q     <= 1'b0;
    end else begin
      case (action)
        ACT_FLUSH, ACT_BUBBLE: begin
          valid_q   <= 1'b0;
          rd_q      <= '0;
          rd_wenb_q <= 1'b0;
          load_q    <= 1'b0;
          csr_q     <= 1'b0;
        end
        ACT_ADVANCE: begin
          valid_q   <= bus.dec_valid;
          rd_q      <= bus.dec_rd;
          // x0 writes are never advertised to the bypass logic.
          rd_wenb_q <= bus.dec_valid & bus.dec_rd_wenb & (bus.dec_rd != 5'd0);
          load_q    <= bus.dec_valid & bus.dec_load;
          csr_q     <= bus.dec_valid & bus.dec_csr;
        end
        default: ;
      endcase
    end
  end

  // Data fields only change on advance; a squashed slot keeps stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      insn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else if (action == ACT_ADVANCE) begin
      pc_q   <= bus.dec_pc;
      insn_q <= bus.dec_insn;
      rs1_q  <= bus.dec_rs1_data;
      rs2_q  <= bus.dec_rs2_data;
    end
  end

  // Hazard statistics: only bubbles are counted, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_use_q <= '0;
      csr_use_q  <= '0;
      bubble_q   <= '0;
    end else if (action == ACT_BUBBLE) begin
      bubble_q <= sat_inc(bubble_q);
      if (bus.dec_load_use) load_use_q <= sat_inc(load_use_q);
      if (bus.dec_csr_use)  csr_use_q  <= sat_inc(csr_use_q);
    end
  end

  assign bus.exe_valid    = valid_q;
  assign bus.exe_pc       = pc_q;
  assign bus.exe_insn     = insn_q;
  assign bus.exe_rs1_data = rs1_q;
  assign bus.exe_rs2_data = rs2_q;
  assign bus.exe_rd       = rd_q;
  assign bus.exe_rd_wenb  = rd_wenb_q;
  assign bus.exe_load     = load_q;
  assign bus.exe_csr      = csr_q;
  assign bus.load_use_cnt = load_use_q;
  assign bus.csr_use_cnt  = csr_use_q;
  assign bus.bubble_cnt   = bubble_q;

endmodule
